// File: rtl/servo_pkg.sv
// Shared register map, control-register layout and angle helper for the servo array controller.
package servo_pkg;

    localparam logic [3:0] TGT_BASE  = 4'h0;
    localparam logic [3:0] CTRL_ADDR = 4'h8;
    localparam logic [3:0] STEP_ADDR = 4'h9;
    localparam logic [3:0] STAT_ADDR = 4'hA;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_SLEW_BIT = 1;

    typedef struct packed {
        logic slew_en;
        logic enable;
    } ctrl_t;

    function automatic logic [7:0] clamp_angle(input logic [7:0] angle, input logic [7:0] max_angle);
        return (angle > max_angle) ? max_angle : angle;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: target register, slewed current angle, per-frame pulse latch and PWM compare.
module servo_channel
    import servo_pkg::*;
#(
    parameter int CNT_W         = 20,
    parameter int MIN_TICKS     = 50000,
    parameter int TICKS_PER_DEG = 277,
    parameter int ANGLE_MAX     = 180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_we_i,
    input  logic [7:0]       tgt_i,
    input  logic             tick_i,
    input  logic             slew_en_i,
    input  logic [7:0]       step_i,
    input  logic             en_nxt_i,
    input  logic [CNT_W-1:0] cnt_nxt_i,
    output logic [7:0]       tgt_o,
    output logic [7:0]       cur_o,
    output logic             pwm_o
);

    logic [7:0]       tgt_q, tgt_d;
    logic [7:0]       cur_q, cur_d;
    logic [7:0]       dist_s, move_s, slew_s;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic             pwm_q, pwm_d;

    // Boundary update reads the pre-write target so a write on the tick cycle lands one frame later
    always_comb begin
        if (tgt_we_i) begin
            tgt_d = clamp_angle(tgt_i, 8'(ANGLE_MAX));
        end else begin
            tgt_d = tgt_q;
        end
        if (tgt_q >= cur_q) begin
            dist_s = tgt_q - cur_q;
        end else begin
            dist_s = cur_q - tgt_q;
        end
        if (step_i < dist_s) begin
            move_s = step_i;
        end else begin
            move_s = dist_s;
        end
        if (tgt_q >= cur_q) begin
            slew_s = cur_q + move_s;
        end else begin
            slew_s = cur_q - move_s;
        end
        if (!tick_i) begin
            cur_d = cur_q;
        end else if (slew_en_i) begin
            cur_d = slew_s;
        end else begin
            cur_d = tgt_q;
        end
        if (tick_i) begin
            pulse_d = CNT_W'(MIN_TICKS) + CNT_W'(cur_d) * CNT_W'(TICKS_PER_DEG);
        end else begin
            pulse_d = pulse_q;
        end
        pwm_d = en_nxt_i && (cnt_nxt_i < pulse_d);
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_q   <= 8'd0;
            cur_q   <= 8'd0;
            pulse_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            pulse_q <= pulse_d;
            pwm_q   <= pwm_d;
        end
    end

    assign tgt_o = tgt_q;
    assign cur_o = cur_q;
    assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_array_ctrl.sv
// Multi-channel hobby-servo PWM controller: frame counter, register file, read mux and channel array.
module servo_array_ctrl
    import servo_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CLK_HZ    = 50_000_000,
    parameter int FRAME_US  = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int ANGLE_MAX = 180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        addr,
    input  logic [15:0]       wr_data,
    output logic [15:0]       rd_data,
    output logic [NUM_CH-1:0] servo_pwm,
    output logic              frame_tick
);

    // 64-bit elaboration math: FRAME_US*CLK_HZ overflows 32 bits at the defaults
    localparam int FRAME_TICKS   = int'(64'(FRAME_US) * 64'(CLK_HZ) / 64'd1_000_000);
    localparam int MIN_TICKS     = int'(64'(MIN_US) * 64'(CLK_HZ) / 64'd1_000_000);
    localparam int TICKS_PER_DEG = int'(64'(MAX_US - MIN_US) * 64'(CLK_HZ) / 64'd1_000_000 / 64'(ANGLE_MAX));
    localparam int CNT_W         = $clog2(FRAME_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_s;
    ctrl_t             ctrl_q, ctrl_d;
    logic [7:0]        step_q, step_d;
    logic [15:0]       rd_q, rd_d;
    logic [7:0]        tgt_s [NUM_CH];
    logic [7:0]        cur_s [NUM_CH];
    logic [NUM_CH-1:0] pwm_s, stat_s;
    logic              unused_s;

    assign unused_s = ^wr_data[15:8];
    assign tick_s   = (cnt_q == CNT_LAST);

    // Counter wrap, control register writes and the registered read mux
    always_comb begin
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        ctrl_d = ctrl_q;
        step_d = step_q;
        if (wr_en && (addr == CTRL_ADDR)) begin
            ctrl_d.enable  = wr_data[CTRL_EN_BIT];
            ctrl_d.slew_en = wr_data[CTRL_SLEW_BIT];
        end else if (wr_en && (addr == STEP_ADDR)) begin
            step_d = wr_data[7:0];
        end else begin
            step_d = step_q;
        end
        rd_d = 16'h0000;
        case (addr)
            CTRL_ADDR: rd_d = 16'(ctrl_q);
            STEP_ADDR: rd_d = {8'h00, step_q};
            STAT_ADDR: rd_d = 16'(stat_s);
            default: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    rd_d = (addr == TGT_BASE + 4'(n)) ? {8'h00, tgt_s[n]} : rd_d;
                end
            end
        endcase
    end

    // Top-level registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            ctrl_q <= '0;
            step_q <= 8'd1;
            rd_q   <= 16'h0000;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_LAST);
            ctrl_q <= ctrl_d;
            step_q <= step_d;
            rd_q   <= rd_d;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        servo_channel #(
            .CNT_W         (CNT_W),
            .MIN_TICKS     (MIN_TICKS),
            .TICKS_PER_DEG (TICKS_PER_DEG),
            .ANGLE_MAX     (ANGLE_MAX)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tgt_we_i  (wr_en && (addr == TGT_BASE + 4'(n))),
            .tgt_i     (wr_data[7:0]),
            .tick_i    (tick_s),
            .slew_en_i (ctrl_q.slew_en),
            .step_i    (step_q),
            .en_nxt_i  (ctrl_d.enable),
            .cnt_nxt_i (cnt_d),
            .tgt_o     (tgt_s[n]),
            .cur_o     (cur_s[n]),
            .pwm_o     (pwm_s[n])
        );
        assign stat_s[n] = (tgt_s[n] != cur_s[n]);
    end

    assign rd_data    = rd_q;
    assign servo_pwm  = pwm_s;
    assign frame_tick = tick_q;

endmodule

// File: doc/servo_array_ctrl.md
SERVO_ARRAY_CTRL -- requirements
Module: servo_array_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, giving the number of servo channels (1..8).
REQ-002 The module SHALL have parameter CLK_HZ, default 50_000_000, giving the input clock frequency.
REQ-003 The module SHALL have parameter FRAME_US, default 20000, giving the PWM frame period in microseconds.
REQ-004 The module SHALL have parameters MIN_US and MAX_US, defaults 1000 and 2000, giving the pulse width at 0 and ANGLE_MAX.
REQ-005 The module SHALL have parameter ANGLE_MAX, default 180, giving the maximum angle in degrees.
REQ-006 The module SHALL have port clk, input, 1 bit, the single system clock.
REQ-007 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-008 The module SHALL have port wr_en, input, 1 bit, register write strobe sampled on the rising edge of clk.
REQ-009 The module SHALL have port addr, input, 4 bits, register address.
REQ-010 The module SHALL have port wr_data, input, 16 bits, register write data.
REQ-011 The module SHALL have port rd_data, output, 16 bits, registered read data.
REQ-012 The module SHALL have port servo_pwm, output, NUM_CH bits, one PWM line per channel.
REQ-013 The module SHALL have port frame_tick, output, 1 bit, a one-cycle pulse on the last cycle of each frame.

Function
REQ-014 The register map SHALL be as follows.
- 0x0..NUM_CH-1: target angle, bits [7:0].
- 0x8: CTRL; bit0 enable, bit1 slew_en.
- 0x9: slew step in degrees per frame, bits [7:0].
- 0xA: status, read-only; bit n = channel n current != target.
- Unmapped addresses: writes ignored, reads return 0.
REQ-015 A target write with value > ANGLE_MAX SHALL store ANGLE_MAX.
REQ-016 rd_data SHALL present the addressed register one cycle after addr is sampled, regardless of wr_en.
REQ-017 A free-running frame counter SHALL count 0..FRAME_TICKS-1 and then wrap to 0.
- FRAME_TICKS = FRAME_US*CLK_HZ/1_000_000.
- frame_tick is asserted when the count equals FRAME_TICKS-1.
REQ-018 On frame_tick, each channel's current angle SHALL update as follows.
- slew_en=0: current = target.
- slew_en=1: current moves toward target by min(step, |target-current|).
- step=0 with slew_en=1: current is frozen.
REQ-019 Also on frame_tick, each channel SHALL latch pulse_ticks from the updated current angle, so the pulse width never changes mid-frame.
- pulse_ticks = MIN_TICKS + current*TICKS_PER_DEG.
- MIN_TICKS = MIN_US*CLK_HZ/1e6.
- TICKS_PER_DEG = floor((MAX_US-MIN_US)*CLK_HZ/1e6/ANGLE_MAX), computed at elaboration with no runtime divide.
REQ-020 servo_pwm[n] SHALL be registered and equal (enable && frame_count < pulse_ticks[n]).
REQ-021 A target write in the same cycle as frame_tick SHALL be stored, but that boundary's update SHALL use the old target.
REQ-022 Clearing enable SHALL force all servo_pwm low from the next cycle, while the counter and slew continue to run.
REQ-023 Setting enable mid-frame SHALL take effect on the next clock, with no extra pulse and no truncated-pulse guarantee for that frame.
REQ-024 All arithmetic SHALL be unsigned.
- Angles are 8 bits.
- pulse_ticks and the frame counter are clog2(FRAME_TICKS) bits wide.
- |target-current| never underflows.

Reset
REQ-025 On reset, registers SHALL take these values.
- Frame counter = 0.
- All targets, current angles and pulse_ticks = 0.
- enable = 0, slew_en = 0, step = 1.
REQ-026 On reset, servo_pwm, rd_data and frame_tick SHALL be 0 from the next clock.
REQ-027 A reset asserted mid-frame SHALL abort the frame, and the next frame SHALL start at count 0 one cycle after reset deasserts.

Structure
REQ-028 Package servo_pkg SHALL hold the register address constants (TGT_BASE, CTRL_ADDR=0x8, STEP_ADDR=0x9, STAT_ADDR=0xA) and the CTRL bit positions.
REQ-029 The top SHALL own the frame counter, register decode and read mux.
REQ-030 Sub-module servo_channel, instantiated NUM_CH times, SHALL hold the target, current angle, slew logic, pulse_ticks latch and PWM compare.

Verification (defaults: CLK_HZ=50M, FRAME_TICKS=1_000_000, MIN_TICKS=50000, TICKS_PER_DEG=277)
REQ-031 Write ch0=90, CTRL=0x1 -> from the second frame, servo_pwm[0] is high for exactly 74930 cycles per 1_000_000-cycle frame, and other channels are high for 50000 cycles.
REQ-032 Write ch1=200 -> a read of addr 1 returns 180 and the pulse is 99860 cycles.
REQ-033 Write CTRL=0x3, step=2, ch2=10 from 0 -> successive frames give pulses of 50554, 51108, 51662, 52216, 52770, then hold; status bit2 clears after the fifth frame_tick.
REQ-034 Write ch3=50 on the frame_tick cycle -> the next frame still uses the old angle and the following frame uses 50.
REQ-035 Assert reset for 3 cycles mid-pulse -> all outputs 0, rd_data 0, and the next frame_tick comes exactly FRAME_TICKS cycles after reset deasserts.
REQ-036 Run with CTRL=0x0 and ch0=90 -> servo_pwm stays 0 throughout, and setting enable produces correct pulses from the next frame.
